// File: rtl/hs32_memarb_if.sv
// rtl/hs32_memarb_if.sv - client-channel and external-bus signal bundle for hs32_memarb
interface hs32_memarb_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_dtw;
  logic [NCH-1:0]    ch_rw;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_err;
  logic [DW-1:0]     ch_dtr;
  logic [NCH-1:0]    gnt;
  logic [AW-1:0]     addr;
  logic              rw;
  logic [DW-1:0]     dout;
  logic              valid;
  logic [DW-1:0]     din;
  logic              done;

  // master: the arbiter itself; slave: the clients plus external memory
  modport master (
    input  ch_addr, ch_dtw, ch_rw, ch_req, din, done,
    output ch_ack, ch_err, ch_dtr, gnt, addr, rw, dout, valid
  );

  modport slave (
    output ch_addr, ch_dtw, ch_rw, ch_req, din, done,
    input  ch_ack, ch_err, ch_dtr, gnt, addr, rw, dout, valid
  );
endinterface

// File: rtl/hs32_memarb.sv
// rtl/hs32_memarb.sv - round-robin N-channel memory arbiter, one valid/done bus transaction at a time
// Optional bus timeout with error flag when HS32_MEMARB_TIMEOUT_EN is defined.
module hs32_memarb #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  hs32_memarb_if.master bus
);
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1 || NCH > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("hs32_memarb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    last_q, last_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    dtr_q, dtr_d;

  logic [LW-1:0]    sel;
  logic             any_req;

`ifdef HS32_MEMARB_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
  logic [NCH-1:0]   err_q, err_d;
  logic             tmo;

  // the cycle in which the counter would step onto TIMEOUT is the expiry cycle
  assign tmo = (cnt_q == 16'(TIMEOUT - 1));
`endif

  // Round-robin search: first requester after the last granted channel, wrapping.
  always_comb begin
    int            idx;
    logic [LW-1:0] idx_l;
    any_req = 1'b0;
    sel     = '0;
    idx     = 0;
    idx_l   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      idx_l = LW'(idx);
      if (!any_req && bus.ch_req[idx_l]) begin
        any_req = 1'b1;
        sel     = idx_l;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    dtr_d   = dtr_q;
`ifdef HS32_MEMARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = BUSY;
          last_d     = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          addr_d     = bus.ch_addr[sel*AW +: AW];
          rw_d       = bus.ch_rw[sel];
          dout_d     = bus.ch_dtw[sel*DW +: DW];
          valid_d    = 1'b1;
`ifdef HS32_MEMARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
        // done takes priority over an expiring timeout in the same cycle
        if (bus.done) begin
          valid_d = 1'b0;
          ack_d   = gnt_q;
          if (!rw_q) dtr_d = bus.din;
          state_d = ACK;
        end
`ifdef HS32_MEMARB_TIMEOUT_EN
        else if (tmo) begin
          valid_d = 1'b0;
          ack_d   = gnt_q;
          err_d   = gnt_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ACK: begin
        ack_d   = '0;
        gnt_d   = '0;
`ifdef HS32_MEMARB_TIMEOUT_EN
        err_d   = '0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= LW'(NCH - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      dtr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      dtr_q   <= dtr_d;
    end
  end

`ifdef HS32_MEMARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.ch_err = err_q;
`else
  assign bus.ch_err = '0;
`endif

  assign bus.gnt    = gnt_q;
  assign bus.ch_ack = ack_q;
  assign bus.ch_dtr = dtr_q;
  assign bus.addr   = addr_q;
  assign bus.rw     = rw_q;
  assign bus.dout   = dout_q;
  assign bus.valid  = valid_q;
endmodule

// File: tb/tb_hs32_memarb.sv
// tb/tb_hs32_memarb.sv - self-checking bench for hs32_memarb (NCH=4, TIMEOUT=8)
module tb_hs32_memarb;
  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hs32_memarb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus();

  hs32_memarb #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] a_tab [NCH];
  logic [31:0] d_tab [NCH];
  int          last_m;
  logic [31:0] dtr_m;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rwm;
    int          lat;
    logic [31:0] din;
    int          eg;
    logic [31:0] edtr;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction: request, grant checks, lat BUSY cycles, done, ack, return to IDLE.
  task automatic do_txn(input logic [3:0] req, input logic [3:0] rwm, input int lat,
                        input logic [31:0] dv, input int eg, input logic [31:0] edtr,
                        input string tag);
    bus.ch_rw  = rwm;
    bus.ch_req = req;
    bus.done   = 1'b0;
    step();
    chk({tag, ".gnt"}, bus.gnt, 64'(4'b0001 << eg));
    chk({tag, ".vrw"}, {bus.valid, bus.rw}, {1'b1, rwm[eg]});
    chk({tag, ".addr"}, bus.addr, a_tab[eg]);
    chk({tag, ".dout"}, bus.dout, d_tab[eg]);
    bus.ch_req = '0;
    for (int i = 0; i < lat; i++) begin
      step();
      chk({tag, ".busy"}, {bus.valid, bus.ch_ack, bus.addr}, {1'b1, 4'b0000, a_tab[eg]});
    end
    bus.done = 1'b1;
    bus.din  = dv;
    step();
    bus.done = 1'b0;
    bus.din  = $urandom;
    chk({tag, ".ack"}, bus.ch_ack, 64'(4'b0001 << eg));
    chk({tag, ".dtr"}, bus.ch_dtr, edtr);
    chk({tag, ".verr"}, {bus.valid, bus.ch_err}, 5'b0);
    step();
    chk({tag, ".idle"}, {bus.ch_ack, bus.gnt}, 8'b0);
  endtask

  initial begin
    logic [3:0]  mask;
    logic [3:0]  rwm;
    logic [31:0] dv;
    int          eg;
    int          lat;
    int          n;
    int          wd_bad;
    int          ack_ch  [$];
    int          ack_cyc [$];
    int          rr_exp  [5];

    a_tab = '{32'h0000_1000, 32'h0000_0020, 32'h0000_3000, 32'h0000_4000};
    d_tab = '{32'hA0A0_0000, 32'h1234_5678, 32'h2222_2222, 32'h3333_3333};
    for (int i = 0; i < NCH; i++) begin
      bus.ch_addr[i*AW +: AW] = a_tab[i];
      bus.ch_dtw[i*DW +: DW]  = d_tab[i];
    end
    bus.ch_rw  = '0;
    bus.ch_req = '0;
    bus.din    = '0;
    bus.done   = 1'b0;

    // grant order hand-derived from round-robin starting at last=3
    vt[0] = '{4'b0001, 4'b0000, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vt[1] = '{4'b0010, 4'b0010, 2, 32'h1111_1111, 1, 32'hDEAD_BEEF};
    vt[2] = '{4'b1111, 4'b0000, 0, 32'h0000_00A1, 2, 32'h0000_00A1};
    vt[3] = '{4'b1111, 4'b0000, 0, 32'h0000_00A2, 3, 32'h0000_00A2};
    vt[4] = '{4'b1111, 4'b0000, 1, 32'h0000_00A3, 0, 32'h0000_00A3};
    vt[5] = '{4'b1111, 4'b0000, 0, 32'h0000_00A4, 1, 32'h0000_00A4};
    vt[6] = '{4'b0001, 4'b0000, 1, 32'h0000_0005, 0, 32'h0000_0005};
    vt[7] = '{4'b1001, 4'b0000, 0, 32'h0000_0006, 3, 32'h0000_0006};
    vt[8] = '{4'b0110, 4'b0100, 3, 32'h0000_0007, 1, 32'h0000_0007};
    vt[9] = '{4'b0101, 4'b0100, 0, 32'h0000_0008, 2, 32'h0000_0007};

    reset = 1'b1;
    #2 reset = 1'b0;
    step();
    step();
    chk("rst.strobes", {bus.gnt, bus.ch_ack, bus.ch_err, bus.valid, bus.rw}, 14'b0);
    chk("rst.addr", bus.addr, 32'h0);
    chk("rst.dout", bus.dout, 32'h0);
    chk("rst.dtr", bus.ch_dtr, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      do_txn(vt[i].req, vt[i].rwm, vt[i].lat, vt[i].din, vt[i].eg, vt[i].edtr,
             $sformatf("vec%0d", i));
    last_m = vt[9].eg;
    dtr_m  = vt[9].edtr;

    // randomized traffic against the round-robin reference
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(0, 15));
      rwm  = 4'($urandom);
      lat  = $urandom_range(0, 3);
      dv   = $urandom;
      if (mask == 4'b0) begin
        bus.ch_req = '0;
        step();
        chk("rnd.noreq", {bus.valid, bus.gnt}, 5'b0);
      end else begin
        eg = -1;
        for (int k = 1; k <= NCH; k++)
          if (eg < 0 && mask[(last_m + k) % NCH]) eg = (last_m + k) % NCH;
        if (!rwm[eg]) dtr_m = dv;
        do_txn(mask, rwm, lat, dv, eg, dtr_m, $sformatf("rnd%0d", t));
        last_m = eg;
      end
    end

    // asynchronous reset in the middle of a BUSY transaction
    bus.ch_rw  = '0;
    bus.ch_req = 4'b0100;
    step();
    bus.ch_req = '0;
    chk("mid.valid_before", bus.valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid.cleared", {bus.valid, bus.gnt, bus.ch_ack}, 9'b0);
    step();
    reset = 1'b1;

    // all four requesting with done held high: order 0,1,2,3,0, acks 3 cycles apart
    rr_exp     = '{0, 1, 2, 3, 0};
    bus.ch_req = 4'b1111;
    bus.done   = 1'b1;
    bus.din    = 32'hC0DE_0000;
    for (int c = 0; c < 30 && ack_ch.size() < 5; c++) begin
      step();
      if (bus.ch_ack != '0) begin
        ack_ch.push_back($clog2(bus.ch_ack));
        ack_cyc.push_back(c);
      end
    end
    bus.ch_req = '0;
    bus.done   = 1'b0;
    chk("rr.count", ack_ch.size(), 5);
    for (int i = 0; i < ack_ch.size() && i < 5; i++)
      chk($sformatf("rr.order%0d", i), ack_ch[i], rr_exp[i]);
    for (int i = 1; i < ack_cyc.size(); i++)
      chk($sformatf("rr.gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
    chk("rr.dtr", bus.ch_dtr, 32'hC0DE_0000);
    step();
    step();

    // ch1 raises and withdraws its request while ch0 is BUSY
    wd_bad     = 0;
    bus.ch_req = 4'b0001;
    step();
    chk("wd.gnt0", bus.gnt, 4'b0001);
    bus.ch_req = 4'b0010;
    step();
    if (bus.gnt[1] || bus.ch_ack[1]) wd_bad++;
    bus.ch_req = '0;
    step();
    if (bus.gnt[1] || bus.ch_ack[1]) wd_bad++;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("wd.ack0", bus.ch_ack, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.gnt[1] || bus.ch_ack[1] || bus.valid) wd_bad++;
    end
    chk("wd.never_ch1", wd_bad, 0);

`ifdef HS32_MEMARB_TIMEOUT_EN
    bus.ch_req = 4'b0100;
    step();
    bus.ch_req = '0;
    n = 0;
    while (bus.ch_ack == '0 && n < 20) begin
      step();
      n++;
    end
    chk("tmo.cycles", n, 8);
    chk("tmo.ackerr", {bus.ch_ack, bus.ch_err, bus.valid}, {4'b0100, 4'b0100, 1'b0});
    step();
    bus.ch_req = 4'b0100;
    step();
    bus.ch_req = '0;
    for (int i = 0; i < 7; i++) step();
    bus.done = 1'b1;
    bus.din  = 32'h5A5A_5A5A;
    step();
    bus.done = 1'b0;
    chk("tmo.late_done", {bus.ch_ack, bus.ch_err}, {4'b0100, 4'b0000});
    chk("tmo.late_dtr", bus.ch_dtr, 32'h5A5A_5A5A);
    step();
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hs32_memarb.md
# hs32_memarb

Parametrised N-channel memory arbiter for the HS32 core, replacing the fixed two-channel execute/fetch arbiter. Each client channel (execute, fetch, and later DMA or debug) raises a request. The block grants one channel at a time using round-robin priority and runs a single `valid`/`done` transaction on the external bus. It then returns read data and a one-cycle acknowledge to the granted channel. It sits between the CPU pipeline stages and the external memory interface in `hs32_cpu`.

## Interface
Parameters:
- `NCH`, 2: number of client channels, 1..16. Channel 0 = execute, channel 1 = fetch.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 255: bus timeout in cycles, 1..65535. Used only with the macro below.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ch_addr` in NCH*AW: per-channel address. Channel i occupies bits [i*AW +: AW].
- `ch_dtw` in NCH*DW: per-channel write data, packed the same way.
- `ch_rw` in NCH: per-channel direction. 1 = write, 0 = read.
- `ch_req` in NCH: per-channel request.
- `ch_ack` out NCH: per-channel one-cycle completion pulse.
- `ch_err` out NCH: per-channel error flag, valid only while the matching `ch_ack` is high.
- `ch_dtr` out DW: read data, shared by all channels. Valid while any `ch_ack` is high.
- `gnt` out NCH: one-hot current grant, for debug and the pipeline controller.
- `addr` out AW: external address.
- `rw` out 1: external direction.
- `dout` out DW: external write data.
- `valid` out 1: external transaction in progress.
- `din` in DW: external read data.
- `done` in 1: external completion.

## Operation
- State machine: IDLE, BUSY, ACK.
- IDLE, when any `ch_req` is high:
  - Select grant g as the first requesting channel, searching from `last+1` upward and wrapping modulo NCH.
  - Register `addr`, `rw` and `dout` from channel g. Set `valid`=1 and `gnt`=1<<g. Set `last`=g. Go to BUSY.
- IDLE, when no `ch_req` is high: stay in IDLE with all strobes low.
- BUSY, when `done`=1 is sampled:
  - Set `valid`=0 and `ch_ack[g]`=1.
  - For reads, capture `din` into `ch_dtr`. For writes, `ch_dtr` is unchanged.
  - Go to ACK.
- ACK:
  - Clear `ch_ack` and `gnt`. Go to IDLE.
  - Any request from g still visible in this cycle is ignored.
- Channel contract:
  - Hold `ch_addr`, `ch_dtw` and `ch_rw` stable from `ch_req` rising until `ch_ack` is seen.
  - Drop `ch_req`, or present a new request, on the edge where `ch_ack` is sampled.
- Requests are not latched. Deasserting `ch_req` before a grant is legal and withdraws the request.
- `addr`, `rw` and `dout` are held at their granted values until the next grant. They are never changed during BUSY.
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - `last` = NCH-1, so channel 0 wins the first arbitration.
  - Timeout counter = 0.
- Reset asserted mid-transaction: `valid`, `ch_ack` and `gnt` clear immediately and asynchronously. The transaction is abandoned with no acknowledge.
- NCH=1: the grant is always channel 0 and the same state sequence applies.

## Timing
- Request sampled at edge e0 → `valid`=1 after e0.
- `done` sampled at edge e1 (e1 ≥ e0+1) → `ch_ack` and `ch_dtr` valid after e1.
- → IDLE after e1+1. The next grant is at the following edge.
- Minimum of 3 cycles per transaction. Back-to-back grants have 1 idle cycle between them.
- `done` is ignored outside BUSY.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness bound: a continuously requesting channel waits at most NCH-1 transactions.

## Configuration
- Macro: `HS32_MEMARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle where `done`=0.
  - When the counter reaches `TIMEOUT` with `done` still 0:
    - Set `valid`=0, `ch_ack[g]`=1 and `ch_err[g]`=1. `ch_dtr` is unchanged.
    - Go to ACK.
  - If `done`=1 in that same cycle, the transaction completes normally and `ch_err`=0.
- Undefined:
  - No counter is built. `ch_err` is tied to 0.
  - BUSY waits indefinitely for `done`. `TIMEOUT` is ignored.

## Test plan
- Single read: NCH=2, ch0 reads 0x0000_1000 and the bus returns `done` with `din`=0xDEAD_BEEF one cycle later → `ch_ack[0]` pulses exactly 1 cycle with `ch_dtr`=0xDEAD_BEEF. `ch_ack[1]` stays 0.
- Write: ch1 writes 0x1234_5678 to 0x20 → `addr`=0x20, `rw`=1, `dout`=0x1234_5678 while `valid`=1. `ch_dtr` keeps its previous value.
- Round-robin: NCH=4, all four requests held high, `done` returned immediately each time → grant order 0,1,2,3,0, with `ch_ack` pulses spaced 3 cycles apart.
- Reset mid-BUSY: assert `reset`=0 between edges while `valid`=1 → `valid`, `gnt` and `ch_ack` are 0 before the next edge. After release, ch0 wins the first arbitration.
- Timeout (macro defined, `TIMEOUT`=8): `done` held at 0 → after 8 BUSY cycles, `ch_ack[g]`=1 and `ch_err[g]`=1 and `valid`=0. With `done` arriving in the 8th cycle instead → `ch_err`=0.
- Request withdrawal: ch1 raises and drops `ch_req` while ch0 is BUSY → ch1 is never granted and never acknowledged.
